// File: rtl/bit4_parallel_sub.sv
// bit4_parallel_sub: registered WIDTH-bit ripple subtractor.
//
// The datapath is a chain of WIDTH full-adder cells fed with a, ~b and a
// carry-in (c_in). With c_in=1 the chain computes a - b. With c_in=0 it
// computes a - b - 1. Both the difference and the borrow flag (the inverted
// final carry) are captured in output registers, so the block behaves as a
// one-cycle arithmetic stage.
//
// Handshake: in_valid qualifies a/b/c_in on the rising edge where it is
// sampled. out_valid is high for exactly the following cycle, and
// diff/b_out/ovf carry that result during that cycle. There is no ready or
// backpressure, so the consumer must take the result in the cycle that
// out_valid is high. On cycles without in_valid the result registers hold
// their previous values.
//
// Optional feature macro: BIT4_PARALLEL_SUB_OVF_EN adds the registered signed
// overflow output ovf. When the macro is not defined, ovf and its logic are
// absent.

module bit4_parallel_sub #(
    parameter int WIDTH = 4
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             in_valid,
    input  logic [WIDTH-1:0] a,
    input  logic [WIDTH-1:0] b,
    input  logic             c_in,
    output logic [WIDTH-1:0] diff,
    output logic             b_out,
    output logic             out_valid
`ifdef BIT4_PARALLEL_SUB_OVF_EN
    ,
    output logic             ovf
`endif
);

    localparam int MSB = WIDTH - 1;

    // Subtrahend is inverted ahead of the adder chain.
    logic [WIDTH-1:0] b_inv;
    // carry[i] enters cell i, and carry[WIDTH] leaves the last cell.
    logic [WIDTH:0]   carry;
    logic [WIDTH-1:0] sum;
    logic             borrow_next;

    assign b_inv    = ~b;
    assign carry[0] = c_in;

    // Ripple chain of full-adder cells. Cell i adds a[i] and ~b[i] to the
    // carry coming from cell i-1.
    for (genvar i = 0; i < WIDTH; i++) begin : g_cell
        logic p;
        assign p          = a[i] ^ b_inv[i];
        assign sum[i]     = p ^ carry[i];
        assign carry[i+1] = (a[i] & b_inv[i]) | (p & carry[i]);
    end

    // No carry out of a + ~b + c_in means the unsigned result wrapped below
    // zero.
    assign borrow_next = ~carry[WIDTH];

    // Result and valid registers. Reset takes priority over a same-cycle
    // in_valid, so that operation is dropped.
    always_ff @(posedge clk) begin
        if (rst) begin
            diff      <= '0;
            b_out     <= 1'b0;
            out_valid <= 1'b0;
        end else begin
            out_valid <= in_valid;
            if (in_valid) begin
                diff  <= sum;
                b_out <= borrow_next;
            end
        end
    end

`ifdef BIT4_PARALLEL_SUB_OVF_EN
    // Signed overflow: the operands have different signs and the result sign
    // differs from the minuend's sign.
    logic ovf_next;

    assign ovf_next = (a[MSB] != b[MSB]) && (sum[MSB] != a[MSB]);

    // Overflow register, captured together with diff.
    always_ff @(posedge clk) begin
        if (rst) begin
            ovf <= 1'b0;
        end else if (in_valid) begin
            ovf <= ovf_next;
        end
    end
`endif

endmodule

// File: tb/tb_bit4_parallel_sub.sv
// tb_bit4_parallel_sub: directed checks plus a full a/b/c_in sweep for
// bit4_parallel_sub (WIDTH=4). Inputs change on the falling edge. Outputs are
// sampled 1 ns after the rising edge.

module tb_bit4_parallel_sub;

    logic       clk;
    logic       rst;
    logic       in_valid;
    logic [3:0] a;
    logic [3:0] b;
    logic       c_in;
    logic [3:0] diff;
    logic       b_out;
    logic       out_valid;
`ifdef BIT4_PARALLEL_SUB_OVF_EN
    logic       ovf;
`endif

    int n_checks;
    int n_fail;

    bit4_parallel_sub #(.WIDTH(4)) dut (
        .clk       (clk),
        .rst       (rst),
        .in_valid  (in_valid),
        .a         (a),
        .b         (b),
        .c_in      (c_in),
        .diff      (diff),
        .b_out     (b_out),
        .out_valid (out_valid)
`ifdef BIT4_PARALLEL_SUB_OVF_EN
        ,
        .ovf       (ovf)
`endif
    );

    // Clock and reset setup.
    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Compare one observed value with its expected value.
    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    // Drive one cycle of inputs, then wait until just after the rising edge.
    task automatic drive(input logic r, input logic v, input logic [3:0] ai,
                         input logic [3:0] bi, input logic ci);
        @(negedge clk);
        rst      = r;
        in_valid = v;
        a        = ai;
        b        = bi;
        c_in     = ci;
        @(posedge clk);
        #1;
    endtask

    // Check all registered outputs against the expected values.
    task automatic check_out(input string tag, input logic [3:0] e_diff, input logic e_bout,
                             input logic e_ov, input logic e_ovf);
        check({tag, ".diff"}, 32'(diff), 32'(e_diff));
        check({tag, ".b_out"}, 32'(b_out), 32'(e_bout));
        check({tag, ".out_valid"}, 32'(out_valid), 32'(e_ov));
`ifdef BIT4_PARALLEL_SUB_OVF_EN
        check({tag, ".ovf"}, 32'(ovf), 32'(e_ovf));
`else
        if (e_ovf === 1'bx) n_checks = n_checks;  // ovf not built
`endif
    endtask

    initial begin
        int sa, sb, r, ur;
        logic [3:0] e_d;
        logic e_b, e_o;
        n_checks = 0;
        n_fail   = 0;
        rst = 1'b1; in_valid = 1'b0; a = '0; b = '0; c_in = 1'b0;

        drive(1, 0, 4'h0, 4'h0, 0);
        drive(1, 0, 4'h0, 4'h0, 0);
        check_out("reset", 4'h0, 0, 0, 0);

        // Basic subtract.
        drive(0, 1, 4'b0101, 4'b0001, 1);
        check_out("basic", 4'b0100, 0, 1, 0);
        // Underflow.
        drive(0, 1, 4'b0001, 4'b0101, 1);
        check_out("underflow", 4'b1100, 1, 1, 0);
        // Carry-in zero.
        drive(0, 1, 4'b0101, 4'b0001, 0);
        check_out("cin0", 4'b0011, 0, 1, 0);
        // Equal operands with carry-in zero.
        drive(0, 1, 4'b0111, 4'b0111, 0);
        check_out("equal_cin0", 4'b1111, 1, 1, 0);

        // Hold: in_valid low while the operands keep changing.
        drive(0, 0, 4'b1010, 4'b0011, 1);
        check_out("hold0", 4'b1111, 1, 0, 0);
        drive(0, 0, 4'b0000, 4'b1111, 0);
        check_out("hold1", 4'b1111, 1, 0, 0);
        drive(0, 0, 4'b1111, 4'b0001, 1);
        check_out("hold2", 4'b1111, 1, 0, 0);

        // Reset beats in_valid.
        drive(0, 1, 4'b0001, 4'b0101, 1);
        check_out("pre_reset", 4'b1100, 1, 1, 0);
        drive(1, 1, 4'b1111, 4'b0000, 1);
        check_out("reset_wins", 4'h0, 0, 0, 0);
        // First operation after reset is released.
        drive(0, 1, 4'b0101, 4'b0001, 1);
        check_out("first_after_rst", 4'b0100, 0, 1, 0);

        // Signed overflow: 7 - (-8).
        drive(0, 1, 4'b0111, 4'b1000, 1);
        check_out("overflow", 4'b1111, 1, 1, 1);

        // Back-to-back sweep of all a/b/c_in combinations against the model.
        for (int ci = 0; ci < 2; ci++) begin
            for (int ai = 0; ai < 16; ai++) begin
                for (int bi = 0; bi < 16; bi++) begin
                    drive(0, 1, 4'(ai), 4'(bi), 1'(ci));
                    ur  = ai - bi - (1 - ci);
                    e_d = 4'(ur & 15);
                    e_b = (ur < 0);
                    sa  = (ai > 7) ? ai - 16 : ai;
                    sb  = (bi > 7) ? bi - 16 : bi;
                    r   = sa - sb - (1 - ci);
                    e_o = (r < -8) || (r > 7);
                    check_out("sweep", e_d, e_b, 1, e_o);
                end
            end
        end

        drive(0, 0, 4'h0, 4'h0, 0);
        check("sweep_end.out_valid", 32'(out_valid), 32'd0);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
